// File: rtl/codec_cfg_seq.sv
// Audio-codec configuration sequencer: write-only I2C master that plays a fixed init table and runtime register writes.
// Define CODEC_CFG_DEBUG_EN to expose state_o / word_o / bit_o for observation.
module codec_cfg_seq #(
  parameter int unsigned CLK_DIV  = 32,
  parameter logic [7:0]  DEV_BYTE = 8'h34
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  input  logic       play_req,
  input  logic       rec_req,
  input  logic       vol_req,
  input  logic [6:0] vol_val,
  output logic       i2c_sclk,
  output logic       i2c_sdat_oe,
  input  logic       i2c_sdat_i,
  output logic       busy,
  output logic       done,
  output logic       ack_err
`ifdef CODEC_CFG_DEBUG_EN
  ,
  output logic [2:0] state_o,
  output logic [3:0] word_o,
  output logic [4:0] bit_o
`endif
);

  localparam int QW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    BIT   = 3'd3,
    ACK   = 3'd4,
    STOP  = 3'd5,
    GAP   = 3'd6
  } state_t;

  state_t        state, state_d;
  logic [QW-1:0] q_cnt;
  logic [3:0]    qtr;
  logic [3:0]    qtr_last;
  logic [4:0]    bit_cnt;
  logic [23:0]   shift;
  logic [3:0]    word;
  logic          init_active;
  logic          nack;
  logic [3:0]    pend;       // {init, play, rec, vol}
  logic [3:0]    req_q;
  logic [3:0]    req_now;
  logic [3:0]    req_edge;
  logic [3:0]    grant;
  logic [15:0]   frame_sel;  // {reg[6:0], data[8:0]}
  logic          tick, phase_end, ack_sample, init_more;

  function automatic logic [15:0] init_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    init_entry = {7'd15, 9'h000};
      4'd1:    init_entry = {7'd2,  9'h179};
      4'd2:    init_entry = {7'd3,  9'h179};
      4'd3:    init_entry = {7'd4,  9'h012};
      4'd4:    init_entry = {7'd5,  9'h013};
      4'd5:    init_entry = {7'd6,  9'h000};
      4'd6:    init_entry = {7'd7,  9'h042};
      4'd7:    init_entry = {7'd8,  9'h000};
      default: init_entry = {7'd9,  9'h001};
    endcase
  endfunction

  assign tick       = (q_cnt == QW'(CLK_DIV - 1));
  assign phase_end  = tick && (qtr == qtr_last);
  assign ack_sample = (state == ACK) && (qtr == 4'd2) && (q_cnt == QW'(CLK_DIV / 2));
  assign init_more  = init_active && (word != 4'd8);
  assign busy       = (state != IDLE) || init_active;

  // A fresh init_start is ignored while a sequence is running or being accepted.
  assign req_now  = {init_start, play_req, rec_req, vol_req};
  assign req_edge = req_now & ~req_q & {~(init_active | grant[3]), 3'b111};

  always_comb begin
    grant     = 4'b0000;
    frame_sel = {7'd2, 2'b10, vol_val};
    if (init_active) begin
      frame_sel = init_entry(word);
    end else if (pend[3]) begin
      grant[3]  = 1'b1;
      frame_sel = init_entry(4'd0);
    end else if (pend[2]) begin
      grant[2]  = 1'b1;
      frame_sel = {7'd4, 9'h012};
    end else if (pend[1]) begin
      grant[1]  = 1'b1;
      frame_sel = {7'd4, 9'h015};
    end else if (pend[0]) begin
      grant[0]  = 1'b1;
    end
    if (state != ARB) grant = 4'b0000;
  end

  always_comb begin
    state_d     = state;
    i2c_sclk    = 1'b1;
    i2c_sdat_oe = 1'b0;
    qtr_last    = 4'd3;
    case (state)
      IDLE:  if (init_active || (|pend)) state_d = ARB;
      ARB:   state_d = START;
      START: begin
        qtr_last    = 4'd1;
        i2c_sdat_oe = 1'b1;
        if (phase_end) state_d = BIT;
      end
      BIT: begin
        i2c_sclk    = qtr[1];
        i2c_sdat_oe = ~shift[23];
        if (phase_end && (bit_cnt[2:0] == 3'd7)) state_d = ACK;
      end
      ACK: begin
        i2c_sclk = qtr[1];
        if (phase_end) state_d = (nack || (bit_cnt == 5'd24)) ? STOP : BIT;
      end
      STOP: begin
        // Hold SDAT low across the SCLK rise, then release it while SCLK is high.
        i2c_sclk    = (qtr != 4'd0);
        i2c_sdat_oe = (qtr < 4'd2);
        if (phase_end) state_d = GAP;
      end
      GAP: begin
        qtr_last = 4'd15;
        if (phase_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      q_cnt       <= '0;
      qtr         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      word        <= '0;
      init_active <= 1'b0;
      nack        <= 1'b0;
      pend        <= '0;
      req_q       <= '0;
      ack_err     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_d;
      req_q <= req_now;
      pend  <= (pend & ~grant) | req_edge;
      done  <= 1'b0;
      if ((state == IDLE) || (state_d != state) || phase_end) begin
        q_cnt <= '0;
        qtr   <= '0;
      end else if (tick) begin
        q_cnt <= '0;
        qtr   <= qtr + 4'd1;
      end else begin
        q_cnt <= q_cnt + QW'(1);
      end
      case (state)
        ARB: begin
          shift   <= {DEV_BYTE, frame_sel};
          bit_cnt <= '0;
          nack    <= 1'b0;
          if (grant[3]) begin
            init_active <= 1'b1;
            word        <= '0;
            ack_err     <= 1'b0;
          end
        end
        BIT: if (phase_end) begin
          shift   <= {shift[22:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
        end
        ACK: if (ack_sample && i2c_sdat_i) begin
          nack        <= 1'b1;
          ack_err     <= 1'b1;
          init_active <= 1'b0;
        end
        GAP: if (phase_end) begin
          if (init_more) word <= word + 4'd1;
          else           init_active <= 1'b0;
          done <= !(init_more || (|pend));
        end
        default: ;
      endcase
    end
  end

`ifdef CODEC_CFG_DEBUG_EN
  assign state_o = state;
  assign word_o  = word;
  assign bit_o   = bit_cnt;
`endif

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Bench for codec_cfg_seq: I2C slave model decodes frames and ACKs, scoreboard compares against a frame-list model.
module tb_codec_cfg_seq;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init_start = 1'b0, play_req = 1'b0, rec_req = 1'b0, vol_req = 1'b0;
  logic [6:0] vol_val = '0;
  logic       i2c_sclk, i2c_sdat_oe, i2c_sdat_i;
  logic       busy, done, ack_err;
  logic       ack_drive = 1'b0;
`ifdef CODEC_CFG_DEBUG_EN
  logic [2:0] state_o;
  logic [3:0] word_o;
  logic [4:0] bit_o;
`endif

  assign i2c_sdat_i = ~(i2c_sdat_oe | ack_drive);

  codec_cfg_seq #(.CLK_DIV(CLK_DIV), .DEV_BYTE(8'h34)) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .play_req(play_req),
    .rec_req(rec_req), .vol_req(vol_req), .vol_val(vol_val),
    .i2c_sclk(i2c_sclk), .i2c_sdat_oe(i2c_sdat_oe), .i2c_sdat_i(i2c_sdat_i),
    .busy(busy), .done(done), .ack_err(ack_err)
`ifdef CODEC_CFG_DEBUG_EN
    , .state_o(state_o), .word_o(word_o), .bit_o(bit_o)
`endif
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: frames are listed in the order the codec should see them
  logic [23:0] exp_q[$];
  int init_reg[9] = '{15, 2, 3, 4, 5, 6, 7, 8, 9};
  int init_dat[9] = '{'h000, 'h179, 'h179, 'h012, 'h013, 'h000, 'h042, 'h000, 'h001};

  function automatic logic [23:0] mk_frame(input int r, input int d);
    logic [6:0] r7;
    logic [8:0] d9;
    r7 = r[6:0];
    d9 = d[8:0];
    return {8'h34, r7, d9};
  endfunction

  task automatic push_init(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk_frame(init_reg[i], init_dat[i]));
  endtask

  task automatic push_runtime(input logic [2:0] m, input logic [6:0] v);
    if (m[2]) exp_q.push_back(mk_frame(4, 'h012));
    if (m[1]) exp_q.push_back(mk_frame(4, 'h015));
    if (m[0]) exp_q.push_back(mk_frame(2, 256 + int'(v)));
  endtask

  // I2C slave model and scoreboard
  int start_cnt = 0, nack_start = -1, done_cnt = 0, busy_drops = 0;
  int bitpos = 0, nbytes = 0;
  logic in_frame = 1'b0, busy_watch = 1'b0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] shreg = '0;
  logic [23:0] frame = '0;

  task automatic frame_end();
    check_eq("frame_bytes", nbytes, 3);
    check_eq("frame_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) check_eq("frame_data", frame, exp_q.pop_front());
  endtask

  task automatic mon_step();
    logic sda;
    sda = ~(i2c_sdat_oe | ack_drive);
    if (!reset) begin
      in_frame = 1'b0; ack_drive = 1'b0; bitpos = 0;
    end else if (prev_scl && i2c_sclk && prev_sda && !sda) begin
      start_cnt++; in_frame = 1'b1; bitpos = 0; nbytes = 0; frame = '0;
    end else if (prev_scl && i2c_sclk && !prev_sda && sda) begin
      if (in_frame) frame_end();
      in_frame = 1'b0;
    end else if (in_frame && !prev_scl && i2c_sclk) begin
      if (bitpos < 8) begin
        shreg = {shreg[6:0], sda}; bitpos++;
      end else begin
        frame = {frame[15:0], shreg}; nbytes++; bitpos = 0;
      end
    end else if (in_frame && prev_scl && !i2c_sclk) begin
      ack_drive = (bitpos == 8) && !((start_cnt == nack_start) && (nbytes == 2));
    end
    prev_scl = i2c_sclk;
    prev_sda = ~(i2c_sdat_oe | ack_drive);
    if (done) done_cnt++;
    if (busy_watch && !busy && !done) busy_drops++;
  endtask

  initial forever begin
    @(negedge clk);
    mon_step();
  end

  // driver tasks
  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    {init_start, play_req, rec_req, vol_req} = m;
    @(negedge clk);
    {init_start, play_req, rec_req, vol_req} = 4'b0000;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, done_cnt != d0, 1);
  endtask

  initial begin
    int d0, s0, n;
    logic [2:0] m;

    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_sclk", i2c_sclk, 1);
    check_eq("rst_oe", i2c_sdat_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ack_err", ack_err, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("idle_busy", busy, 0);

    // full init sequence
    d0 = done_cnt;
    push_init(9);
    pulse(4'b1000);
    @(negedge clk);
    busy_watch = 1'b1;
    wait_done("init_done", 8000);
    busy_watch = 1'b0;
    check_eq("init_busy_hold", busy_drops, 0);
    repeat (60) @(negedge clk);
    check_eq("init_done_once", done_cnt - d0, 1);
    check_eq("init_ack_err", ack_err, 0);
    check_eq("init_drained", exp_q.size(), 0);

    // volume write with start latency
    vol_val = 7'h55;
    exp_q.push_back(24'h340555);
    @(negedge clk) vol_req = 1'b1;
    @(negedge clk) vol_req = 1'b0;
    @(negedge clk);
    check_eq("lat2_oe", i2c_sdat_oe, 0);
    @(negedge clk);
    check_eq("lat3_oe", i2c_sdat_oe, 1);
    check_eq("lat3_sclk", i2c_sclk, 1);
    wait_done("vol_done", 1500);
    check_eq("vol_drained", exp_q.size(), 0);

    // three simultaneous runtime requests
    d0 = done_cnt;
    push_runtime(3'b111, vol_val);
    pulse(4'b0111);
    wait_done("triple_done", 3000);
    repeat (60) @(negedge clk);
    check_eq("triple_done_once", done_cnt - d0, 1);
    check_eq("triple_drained", exp_q.size(), 0);

    // repeated play requests during init merge into one frame after R9
    d0 = done_cnt;
    push_init(9);
    push_runtime(3'b100, vol_val);
    pulse(4'b1000);
    repeat ($urandom_range(100, 900)) @(negedge clk);
    pulse(4'b0100);
    repeat ($urandom_range(100, 900)) @(negedge clk);
    pulse(4'b0100);
    wait_done("merge_done", 10000);
    repeat (60) @(negedge clk);
    check_eq("merge_done_once", done_cnt - d0, 1);
    check_eq("merge_drained", exp_q.size(), 0);

    // random runtime request mixes
    for (int it = 0; it < 8; it++) begin
      m = 3'($urandom_range(1, 7));
      vol_val = 7'($urandom_range(0, 127));
      push_runtime(m, vol_val);
      pulse({1'b0, m});
      wait_done("rand_done", 3000);
      check_eq("rand_drained", exp_q.size(), 0);
    end

    // NACK on the third byte of init frame 2 aborts the sequence
    s0 = start_cnt;
    nack_start = s0 + 3;
    push_init(3);
    pulse(4'b1000);
    wait_done("nack_done", 4000);
    check_eq("nack_ack_err", ack_err, 1);
    repeat (300) @(negedge clk);
    check_eq("nack_no_more", start_cnt - s0, 3);
    check_eq("nack_drained", exp_q.size(), 0);
    nack_start = -1;

    vol_val = 7'($urandom_range(0, 127));
    push_runtime(3'b001, vol_val);
    pulse(4'b0001);
    wait_done("nack_vol_done", 1500);
    check_eq("ack_err_held", ack_err, 1);

    // new init clears ack_err; reset mid-byte releases the bus
    pulse(4'b1000);
    @(negedge clk);
    @(negedge clk);
    check_eq("reinit_oe", i2c_sdat_oe, 1);
    check_eq("reinit_ack_err", ack_err, 0);
    n = 0;
    while (!(in_frame && bitpos == 4) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("midbyte_reached", n < 2000, 1);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check_eq("abort_sclk", i2c_sclk, 1);
    check_eq("abort_oe", i2c_sdat_oe, 0);
    check_eq("abort_busy", busy, 0);
    reset = 1'b1;
    s0 = start_cnt;
    repeat (600) @(negedge clk);
    check_eq("abort_no_frames", start_cnt - s0, 0);
    check_eq("abort_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/codec_cfg_seq.md
CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 32, meaning system clocks per I2C quarter-bit (minimum 2).
REQ-002 SHALL have parameter DEV_BYTE, default 8'h34, meaning the codec write address byte (7-bit address plus W=0).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port init_start, input, 1 bit: request to run the full initialisation sequence.
REQ-006 SHALL have ports play_req, rec_req and vol_req, input, 1 bit each: runtime reconfiguration requests.
REQ-007 SHALL have port vol_val, input, 7 bits: headphone volume code, sampled when the volume frame is loaded.
REQ-008 SHALL have ports i2c_sclk, output, 1 bit, and i2c_sdat_oe, output, 1 bit (1 = drive SDAT low, 0 = release).
REQ-009 SHALL have port i2c_sdat_i, input, 1 bit: sampled SDAT line.
REQ-010 SHALL have outputs busy, 1 bit; done, 1 bit (one-cycle pulse); and ack_err, 1 bit (sticky).

Function
REQ-011 Each frame SHALL be START, DEV_BYTE, ACK, {reg[6:0], data[8]}, ACK, data[7:0], ACK, STOP, MSB first.
REQ-012 Each bit SHALL last 4 quarters of CLK_DIV clocks: SCLK low, low, high, high; SDAT changes only in quarter 0.
REQ-013 START: SDAT pulled low while SCLK is high for 2 quarters. STOP: SDAT released while SCLK is high for 2 quarters.
REQ-014 FSM states SHALL be IDLE, ARB, START, BIT, ACK, STOP, GAP.
REQ-015 State transitions: IDLE->ARB when any request is pending; ARB->START (1 cycle); START->BIT; BIT->ACK after each 8th bit; ACK->BIT, or ACK->STOP after the third ACK; STOP->GAP; GAP (4 bit periods)->IDLE.
REQ-016 Request inputs SHALL be latched as pending flags on their rising edge; repeated edges before service merge into one.
REQ-017 Priority SHALL be init > play > rec > vol; a pending flag clears when its frame enters START.
REQ-018 The init sequence SHALL issue these 9 frames in order: R15=0x000, R2=0x179, R3=0x179, R4=0x012, R5=0x013, R6=0x000, R7=0x042, R8=0x000, R9=0x001.
REQ-019 The init sequence SHALL run uninterrupted; runtime requests wait until it ends.
REQ-020 play SHALL write R4=0x012; rec SHALL write R4=0x015; vol SHALL write R2={2'b10, vol_val}.
REQ-021 ACK SHALL be sampled at the midpoint of quarter 2 of the ACK bit, with SDAT released; a sample of 1 is a NACK.
REQ-022 On NACK: go to STOP, set ack_err, and abort any remaining init frames.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 done SHALL pulse once on GAP->IDLE when no request is pending.
REQ-025 Latency: a request edge seen in IDLE SHALL assert i2c_sdat_oe=1 with i2c_sclk=1 exactly 3 clocks later (latch, ARB, START).
REQ-026 init_start while the init sequence is running SHALL be ignored; init_start during a runtime frame SHALL pend.
REQ-027 ack_err SHALL clear only on acceptance of a new init sequence.
REQ-028 The frame word index SHALL be 4 bits and SHALL NOT wrap past 8.

Reset
REQ-029 While reset=0 at a clock edge: state=IDLE, i2c_sclk=1, i2c_sdat_oe=0, busy=0, done=0, ack_err=0, all pending flags=0, counters=0.
REQ-030 Reset mid-frame SHALL release both lines on the next edge, with no STOP generated.

Configuration
REQ-031 With CODEC_CFG_DEBUG_EN defined: SHALL add outputs state_o (3 bits, FSM encoding), word_o (4 bits, init index) and bit_o (5 bits, frame bit counter).
REQ-032 With CODEC_CFG_DEBUG_EN undefined: those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (CLK_DIV=4, codec model ACKs unless stated)
REQ-033 Release reset, pulse init_start -> 9 frames matching REQ-018 bit-exactly, busy high throughout, one done pulse, ack_err=0.
REQ-034 Pulse vol_req with vol_val=7'h55 in IDLE -> START after 3 clocks; frame 0x34/0x05/0x55; done pulse.
REQ-035 Pulse rec_req, play_req and vol_req in the same cycle -> frames issued in order R4=0x012, R4=0x015, R2 volume; single done at the end.
REQ-036 Model NACKs the 3rd byte of init frame 2 -> STOP, ack_err=1, no further init frames, ack_err held until the next init_start.
REQ-037 Assert reset=0 mid-byte -> next edge i2c_sclk=1, i2c_sdat_oe=0, busy=0; no frames until a new request.
REQ-038 Pulse play_req twice during init -> exactly one R4=0x012 frame after the R9 frame.
